regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters: the ALU (port A) and the load unit (port B). Valid/ready handshakes, round-robin grant on conflict, one registered commit stage driving WriteAddr/WriteData/RegWrite. Forwards the in-flight commit onto both read paths so readers never see stale data. Sits between the execute/memory stages and the register file.

## Interface
- No parameters; data width fixed at 32 bits, address width fixed at 5 bits.

- Clock  in  1  sole clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clock
- AValid  in  1  ALU requester has a write pending
- AAddr  in  5  ALU destination register
- AData  in  32  ALU result
- AReady  out  1  ALU request accepted this cycle
- BValid  in  1  load unit has a write pending
- BAddr  in  5  load destination register
- BData  in  32  load result
- BReady  out  1  load request accepted this cycle
- WriteAddr  out  5  register file write address
- WriteData  out  32  register file write data
- RegWrite  out  1  register file write enable
- RdAddr1, RdAddr2  in  5 each  read addresses (also driven to the register file)
- RfData1, RfData2  in  32 each  raw register file read data
- FwdData1, FwdData2  out  32 each  read data after forwarding
- LastGrant  out  1  0 = A granted most recently, 1 = B

## Operation
- Commit stage: registers CAddr, CData, CValid; WriteAddr = CAddr, WriteData = CData, RegWrite = CValid.
- Register file accepts one write per cycle, so the commit stage drains every cycle. Arbiter never back-pressures for capacity, only for conflict.
- Grant logic, combinational each cycle:
  - only AValid: grant A.
  - only BValid: grant B.
  - both: grant the requester not named by LastGrant (round robin).
  - neither: no grant.
- AReady/BReady = grant to that port. A transfer occurs when Valid && Ready.
- On a transfer: commit stage loads the granted Addr/Data with CValid = 1, and LastGrant updates to the granted port. With no transfer: CValid = 0, CAddr/CData hold, LastGrant holds.
- Requesters hold Valid, Addr and Data stable until Ready. A Valid dropped without Ready is legal; the request is discarded.
- Forwarding: FwdDataN = CData when CValid && CAddr == RdAddrN, else RfDataN. This covers the cycle in which the commit is presented to the register file but not yet written.
- Same address from both ports on the same cycle: the two writes commit on consecutive cycles in grant order. The later write is the final value.

## Timing
- Reset values: CValid/RegWrite = 0, WriteAddr = 0, WriteData = 0, LastGrant = 1 (so A wins the first conflict), AReady = BReady = 0 while Reset is high.
- Latency: request accepted at edge N; RegWrite high during cycle N+1; register file updated at edge N+2. Forwarded value is visible from cycle N+1.
- Throughput: one write per cycle sustained.
- Starvation bound: a continuously valid requester waits at most 1 cycle.
- Reset asserted mid-operation: the pending commit is discarded (RegWrite low next cycle), and any request presented that cycle is not accepted.

## Configuration
- ZERO_REG_DISCARD_EN defined:
  - Any accepted request with Addr == 0 completes its handshake normally.
  - The commit stage loads CValid = 0, so RegWrite stays low.
  - Forwarding never matches address 0.
  - LastGrant still updates.
- Undefined: register 0 is written and forwarded like any other register.

## Test plan
- Reset then idle: RegWrite = 0, AReady = BReady = 0, FwdData1 = RfData1 for any RdAddr1.
- AValid only, AAddr = 5, AData = 0xDEADBEEF: AReady = 1 at cycle 0. Cycle 1: RegWrite = 1, WriteAddr = 5, WriteData = 0xDEADBEEF. FwdData1 = 0xDEADBEEF with RdAddr1 = 5.
- Both valid for 4 cycles after reset (A: addr 1, B: addr 2): grants A, B, A, B; LastGrant toggles each cycle; RegWrite high on 4 consecutive cycles.
- Both valid, same address 7, AData = 0x11, BData = 0x22, first conflict after reset: commits 0x11 then 0x22; register 7 ends at 0x22.
- Reset asserted the cycle after AValid is accepted: RegWrite = 0 next cycle; register file unchanged.
- With ZERO_REG_DISCARD_EN defined, BValid with BAddr = 0, BData = 0xFF: BReady = 1, RegWrite stays 0, FwdData2 = RfData2 for RdAddr2 = 0. Without the macro: RegWrite = 1, WriteAddr = 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file write port, with a
// single commit stage and read forwarding. Optional: ZERO_REG_DISCARD_EN.
module regfile_wb_arbiter (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        AValid,
  input  logic [4:0]  AAddr,
  input  logic [31:0] AData,
  output logic        AReady,
  input  logic        BValid,
  input  logic [4:0]  BAddr,
  input  logic [31:0] BData,
  output logic        BReady,
  output logic [4:0]  WriteAddr,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  input  logic [4:0]  RdAddr1,
  input  logic [4:0]  RdAddr2,
  input  logic [31:0] RfData1,
  input  logic [31:0] RfData2,
  output logic [31:0] FwdData1,
  output logic [31:0] FwdData2,
  output logic        LastGrant
);

  logic        grantA;
  logic        grantB;
  logic        transfer;
  logic [4:0]  selAddr;
  logic [31:0] selData;
  logic        selWrite;
  logic [4:0]  cAddr;
  logic [31:0] cData;
  logic        cValid;
  logic        lastGrant;
  logic        commitLive;

  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    unique case ({AValid, BValid})
      2'b10: grantA = 1'b1;
      2'b01: grantB = 1'b1;
      2'b11: begin
        grantA = lastGrant;
        grantB = !lastGrant;
      end
      default: ;
    endcase
  end

  assign AReady   = grantA && !Reset;
  assign BReady   = grantB && !Reset;
  assign transfer = AReady || BReady;
  assign selAddr  = AReady ? AAddr : BAddr;
  assign selData  = AReady ? AData : BData;

`ifdef ZERO_REG_DISCARD_EN
  // x0 writes still handshake and rotate priority but never commit
  assign selWrite = transfer && (selAddr != 5'd0);
`else
  assign selWrite = transfer;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cValid    <= 1'b0;
      cAddr     <= 5'd0;
      cData     <= 32'd0;
      lastGrant <= 1'b1;
    end else begin
      cValid <= selWrite;
      if (transfer) begin
        cAddr     <= selAddr;
        cData     <= selData;
        lastGrant <= BReady;
      end
    end
  end

  // a commit caught by reset is dropped before it reaches the register file
  assign commitLive = cValid && !Reset;

  assign WriteAddr = cAddr;
  assign WriteData = cData;
  assign RegWrite  = commitLive;
  assign LastGrant = lastGrant;

  assign FwdData1 = (commitLive && cAddr == RdAddr1) ? cData : RfData1;
  assign FwdData2 = (commitLive && cAddr == RdAddr2) ? cData : RfData2;

endmodule
